// File: rtl/tt_mux_pkg.sv
// rtl/tt_mux_pkg.sv - shared types and slot field layout for the project-select controller
package tt_mux_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GAP   = 2'd1,
      RESET = 2'd2,
      RUN   = 2'd3
   } state_e;

   localparam int TT_IO_W     = 8;
   localparam int TT_OW_W     = 24;

   // Each slot's output word is {uio_oe, uio_out, uo_out}
   localparam int UO_LSB      = 0;
   localparam int UIO_OUT_LSB = 8;
   localparam int UIO_OE_LSB  = 16;

endpackage

// File: rtl/tt_proj_out_mux.sv
// rtl/tt_proj_out_mux.sv - registered selector of one slot's 24-bit output word
module tt_proj_out_mux
   import tt_mux_pkg::*;
#(
   parameter int NUM_PROJ = 16,
   parameter int SEL_W    = 5
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         zero_i,
   input  logic [SEL_W-1:0]             sel_i,
   input  logic [TT_OW_W*NUM_PROJ-1:0]  ow_i,
   output logic [TT_OW_W-1:0]           q_o
);

   logic [TT_OW_W-1:0] slot_w;
   logic [TT_OW_W-1:0] q_q;

   // Loop compare keeps an out-of-range select harmless instead of slicing past the bus
   always_comb begin
      slot_w = '0;
      for (int k = 0; k < NUM_PROJ; k++) begin
         if (sel_i == SEL_W'(k)) begin
            slot_w = ow_i[k*TT_OW_W +: TT_OW_W];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q <= '0;
      end else if (zero_i) begin
         q_q <= '0;
      end else begin
         q_q <= slot_w;
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/tt_proj_mux_ctrl.sv
// rtl/tt_proj_mux_ctrl.sv - sequences project-slot switches (gap, held reset, run) and routes pads
module tt_proj_mux_ctrl
   import tt_mux_pkg::*;
#(
   parameter  int NUM_PROJ = 16,
   parameter  int GAP_CYC  = 4,
   parameter  int RST_CYC  = 8,
   localparam int SEL_W    = $clog2(NUM_PROJ + 1)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         sel_req,
   input  logic [SEL_W-1:0]             sel_addr,
   output logic                         sel_busy,
   output logic                         sel_done,
   output logic [SEL_W-1:0]             act_addr,
   input  logic [TT_IO_W-1:0]           ui_in,
   input  logic [TT_IO_W-1:0]           uio_in,
   output logic [2*TT_IO_W-1:0]         proj_in,
   output logic [NUM_PROJ-1:0]          proj_ena,
   output logic [NUM_PROJ-1:0]          proj_rst_n,
   input  logic [TT_OW_W*NUM_PROJ-1:0]  proj_ow,
   output logic [TT_IO_W-1:0]           uo_out,
   output logic [TT_IO_W-1:0]           uio_out,
   output logic [TT_IO_W-1:0]           uio_oe
);

   localparam int              MAX_CYC  = (GAP_CYC > RST_CYC) ? GAP_CYC : RST_CYC;
   localparam int              CNT_W    = $clog2(MAX_CYC) + 1;
   localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYC - 1);
   localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RST_CYC - 1);
   localparam logic [SEL_W-1:0] NONE     = SEL_W'(NUM_PROJ);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [SEL_W-1:0]  act_q, act_d;
   logic              done_q, done_d;
   logic              slot_on;
   logic              pad_zero;
   logic [TT_OW_W-1:0] pad_w;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      act_d   = act_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE, RUN: begin
            if (sel_req) begin
               act_d   = sel_addr;
               cnt_d   = GAP_LOAD;
               state_d = GAP;
            end
         end
         GAP: begin
            if (cnt_q == '0) begin
               if (act_q < NONE) begin
                  cnt_d   = RST_LOAD;
                  state_d = RESET;
               end else begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RESET: begin
            if (cnt_q == '0) begin
               done_d  = 1'b1;
               state_d = RUN;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         act_q   <= NONE;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         act_q   <= act_d;
         done_q  <= done_d;
      end
   end

   assign slot_on  = (state_q == RESET) || (state_q == RUN);
   assign sel_busy = (state_q == GAP) || (state_q == RESET);
   assign sel_done = done_q;
   assign act_addr = act_q;
   assign proj_in  = slot_on ? {uio_in, ui_in} : '0;

   always_comb begin
      proj_ena   = '0;
      proj_rst_n = '0;
      for (int k = 0; k < NUM_PROJ; k++) begin
         proj_ena[k]   = slot_on && (act_q == SEL_W'(k));
         proj_rst_n[k] = (state_q == RUN) && (act_q == SEL_W'(k));
      end
   end

   // Pads blank on the very edge a switch is accepted, so a leaving slot never drives past RUN
   assign pad_zero = !((state_q == RUN) && (state_d == RUN));

   tt_proj_out_mux #(
      .NUM_PROJ (NUM_PROJ),
      .SEL_W    (SEL_W)
   ) u_out_mux (
      .clk    (clk),
      .rst_n  (rst_n),
      .zero_i (pad_zero),
      .sel_i  (act_q),
      .ow_i   (proj_ow),
      .q_o    (pad_w)
   );

   assign uo_out  = pad_w[UO_LSB      +: TT_IO_W];
   assign uio_out = pad_w[UIO_OUT_LSB +: TT_IO_W];
   assign uio_oe  = pad_w[UIO_OE_LSB  +: TT_IO_W];

endmodule

// File: tb/tb_tt_proj_mux_ctrl.sv
// tb/tb_tt_proj_mux_ctrl.sv - directed bench for two controller configurations
module tb_tt_proj_mux_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   bit fin [2];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : cfg
      localparam int NP = (g == 0) ? 16 : 5;
      localparam int GC = (g == 0) ? 4 : 1;
      localparam int RC = (g == 0) ? 8 : 1;
      localparam int SW = $clog2(NP + 1);
      localparam int A_SECOND = (g == 0) ? 5 : 1;
      localparam int A_IGNORE = (g == 0) ? 9 : 4;
      localparam int A_RERST  = (g == 0) ? 7 : 4;
      localparam logic [15:0] PIN = 16'hC35A;

      logic               rst_n, sel_req, sel_busy, sel_done;
      logic [SW-1:0]      sel_addr, act_addr;
      logic [7:0]         ui_in, uio_in, uo_out, uio_out, uio_oe;
      logic [15:0]        proj_in;
      logic [NP-1:0]      proj_ena, proj_rst_n;
      logic [24*NP-1:0]   proj_ow;

      tt_proj_mux_ctrl #(.NUM_PROJ(NP), .GAP_CYC(GC), .RST_CYC(RC)) dut (
         .clk        (clk),
         .rst_n      (rst_n),
         .sel_req    (sel_req),
         .sel_addr   (sel_addr),
         .sel_busy   (sel_busy),
         .sel_done   (sel_done),
         .act_addr   (act_addr),
         .ui_in      (ui_in),
         .uio_in     (uio_in),
         .proj_in    (proj_in),
         .proj_ena   (proj_ena),
         .proj_rst_n (proj_rst_n),
         .proj_ow    (proj_ow),
         .uo_out     (uo_out),
         .uio_out    (uio_out),
         .uio_oe     (uio_oe)
      );

      function automatic logic [23:0] pad_of(input int k);
         return 24'h906030 + 24'h010101 * 24'(k);
      endfunction

      task automatic cyc(input string ph, input logic [63:0] ena_e, input logic [63:0] rstn_e,
                         input logic busy_e, input logic done_e, input int act_e,
                         input logic [15:0] pin_e, input logic [23:0] pad_e);
         string t;
         t = $sformatf("c%0d_%s", g, ph);
         chk({t, "_ena"},  64'(proj_ena), ena_e);
         chk({t, "_rstn"}, 64'(proj_rst_n), rstn_e);
         chk({t, "_busy"}, 64'(sel_busy), 64'(busy_e));
         chk({t, "_done"}, 64'(sel_done), 64'(done_e));
         chk({t, "_act"},  64'(act_addr), 64'(act_e));
         chk({t, "_pin"},  64'(proj_in), 64'(pin_e));
         chk({t, "_pads"}, 64'({uio_oe, uio_out, uo_out}), 64'(pad_e));
         chk({t, "_1hot"}, 64'($onehot0(proj_ena)), 64'(1));
      endtask

      task automatic do_switch(input int to, input int ign, input bit abort);
         int rlow;
         int ac;
         int other;
         logic [63:0] oh;
         rlow = 0;
         ac   = (RC > 1) ? 1 : 0;
         oh   = 64'(1) << to;
         sel_req  = 1'b1;
         sel_addr = SW'(to);
         @(negedge clk);
         sel_req  = 1'b0;
         for (int c = 0; c < GC; c++) begin
            cyc("gap", 0, 0, 1'b1, 1'b0, to, 16'h0, 24'h0);
            @(negedge clk);
         end
         if (to >= NP) begin
            cyc("idle_done", 0, 0, 1'b0, 1'b1, NP, 16'h0, 24'h0);
            @(negedge clk);
            cyc("idle", 0, 0, 1'b0, 1'b0, NP, 16'h0, 24'h0);
            return;
         end
         for (int c = 0; c < RC; c++) begin
            cyc("rst", oh, 0, 1'b1, 1'b0, to, PIN, 24'h0);
            if (proj_ena[to] && !proj_rst_n[to]) rlow++;
            if (abort && c == ac) begin
               rst_n = 1'b0;
               #1;
               cyc("abort", 0, 0, 1'b0, 1'b0, NP, 16'h0, 24'h0);
               for (int h = 0; h < 2; h++) begin
                  @(negedge clk);
                  cyc("held", 0, 0, 1'b0, 1'b0, NP, 16'h0, 24'h0);
               end
               rst_n = 1'b1;
               @(negedge clk);
               cyc("post_abort", 0, 0, 1'b0, 1'b0, NP, 16'h0, 24'h0);
               return;
            end
            if (ign >= 0 && c == ac) begin
               sel_req  = 1'b1;
               sel_addr = SW'(ign);
            end
            @(negedge clk);
            sel_req = 1'b0;
         end
         chk($sformatf("c%0d_rst_len", g), 64'(rlow), 64'(RC));
         cyc("run_first", oh, oh, 1'b0, 1'b1, to, PIN, 24'h0);
         @(negedge clk);
         cyc("run_live", oh, oh, 1'b0, 1'b0, to, PIN, pad_of(to));
         other = (to + 1) % NP;
         proj_ow[24*other +: 24] = 24'hFFFFFF;
         @(negedge clk);
         cyc("run_isol", oh, oh, 1'b0, 1'b0, to, PIN, pad_of(to));
         proj_ow[24*other +: 24] = pad_of(other);
      endtask

      initial begin
         rst_n    = 1'b0;
         sel_req  = 1'b0;
         sel_addr = '0;
         ui_in    = PIN[7:0];
         uio_in   = PIN[15:8];
         for (int k = 0; k < NP; k++) proj_ow[24*k +: 24] = pad_of(k);
         wait (g == 0 || fin[0]);
         repeat (3) @(negedge clk);
         cyc("reset", 0, 0, 1'b0, 1'b0, NP, 16'h0, 24'h0);
         rst_n = 1'b1;
         @(negedge clk);
         cyc("idle0", 0, 0, 1'b0, 1'b0, NP, 16'h0, 24'h0);
         do_switch(3, -1, 1'b0);
         do_switch(A_SECOND, A_IGNORE, 1'b0);
         do_switch(2, -1, 1'b0);
         do_switch(NP, -1, 1'b0);
         do_switch(A_RERST, -1, 1'b0);
         do_switch(A_RERST, -1, 1'b0);
         do_switch(A_SECOND, -1, 1'b1);
         do_switch(3, -1, 1'b0);
         fin[g] = 1'b1;
      end
   end

   initial begin
      for (int i = 0; i < 20000 && !fin[1]; i++) @(posedge clk);
      chk("finish", 64'(fin[1]), 64'(1));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
